// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, destination select, and an
// iterative 32-step multiply/divide unit that owns HI/LO and stalls the pipe while busy.
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       EX_E,
    input  logic [2:0]       MD_E,
    input  logic [4:0]       Rt_E,
    input  logic [4:0]       Rd_E,
    input  logic [WIDTH-1:0] RD1_E,
    input  logic [WIDTH-1:0] RD2_E,
    input  logic [WIDTH-1:0] SignImm_E,
    input  logic [1:0]       ForwardA_E,
    input  logic [1:0]       ForwardB_E,
    input  logic [WIDTH-1:0] ALUOut_M,
    input  logic [WIDTH-1:0] Result_W,
    output logic [WIDTH-1:0] ALUOut_E,
    output logic [WIDTH-1:0] WriteData_E,
    output logic [4:0]       WriteReg_E,
    output logic             Zero_E,
    output logic             Busy_E
);

    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MFHI  = 3'b101;
    localparam logic [2:0] MD_MFLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] src_a, src_b, alu_res;
    logic             cmp;

    always_comb begin
        case (ForwardA_E)
            2'b10:   src_a = ALUOut_M;
            2'b01:   src_a = Result_W;
            default: src_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b10:   WriteData_E = ALUOut_M;
            2'b01:   WriteData_E = Result_W;
            default: WriteData_E = RD2_E;
        endcase
        src_b = EX_E[3] ? SignImm_E : WriteData_E;
    end

    always_comb begin
        cmp = 1'b0;
        case (EX_E[2:0])
            3'b000:  alu_res = src_a & src_b;
            3'b001:  alu_res = src_a | src_b;
            3'b010:  alu_res = src_a + src_b;
            3'b110:  alu_res = src_a - src_b;
            3'b011:  alu_res = src_a ^ src_b;
            3'b100:  alu_res = ~(src_a | src_b);
            3'b111: begin
                cmp     = $signed(src_a) < $signed(src_b);
                alu_res = {{(WIDTH-1){1'b0}}, cmp};
            end
            3'b101: begin
                cmp     = src_a < src_b;
                alu_res = {{(WIDTH-1){1'b0}}, cmp};
            end
            default: alu_res = '0;
        endcase
        if (MD_E == MD_MFHI)
            ALUOut_E = hi_q;
        else if (MD_E == MD_MFLO)
            ALUOut_E = lo_q;
        else
            ALUOut_E = alu_res;
    end

    assign WriteReg_E = EX_E[4] ? Rd_E : Rt_E;
    assign Zero_E     = (ALUOut_E == '0);
    assign Busy_E     = (state_q == RUN);

    logic             md_start, md_signed, md_div;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0] step_hi, step_lo, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        md_start  = (MD_E == MD_MULT) || (MD_E == MD_MULTU) ||
                    (MD_E == MD_DIV)  || (MD_E == MD_DIVU);
        md_signed = (MD_E == MD_MULT) || (MD_E == MD_DIV);
        md_div    = (MD_E == MD_DIV)  || (MD_E == MD_DIVU);

        // Multiply: add multiplicand into the upper half, then shift the 65-bit pair right.
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        // Divide: shift the next dividend bit into the partial remainder and try a subtract.
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        if (is_div_q) begin
            step_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            {step_hi, step_lo} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        end

        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = dz_q ? '1 : (neg_q ? -step_lo : step_lo);
        rem_fix  = neg_rem_q ? -step_hi : step_hi;

        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;

        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    acc_hi_d  = '0;
                    acc_lo_d  = (md_signed && src_a[WIDTH-1]) ? -src_a : src_a;
                    opb_d     = (md_signed && WriteData_E[WIDTH-1]) ? -WriteData_E : WriteData_E;
                    is_div_d  = md_div;
                    neg_d     = md_signed && (src_a[WIDTH-1] ^ WriteData_E[WIDTH-1]);
                    neg_rem_d = md_signed && md_div && src_a[WIDTH-1];
                    dz_d      = md_div && (WriteData_E == '0);
                end
            end
            RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = IDLE;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its registered outputs (EX_E, Rt_E, Rd_E, RD1_E, RD2_E, SignImm_E). Its results feed the EX/MEM register.
- Combinational path: operand forwarding muxes, a single-cycle ALU, and destination-register selection.
- Sequential part: a 32-iteration multiply/divide unit that holds the HI/LO registers and raises a stall request while it runs.

## Interface
Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- EX_E  in  5  {RegDst, ALUSrc, ALUControl[2:0]}.
- MD_E  in  3  mult/div op: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO, 111 reserved (treated as none).
- Rt_E, Rd_E  in  5 each  candidate destination registers.
- RD1_E, RD2_E, SignImm_E  in  32 each  register operands and sign-extended immediate.
- ForwardA_E, ForwardB_E  in  2 each  00 RDx_E, 10 ALUOut_M, 01 Result_W, 11 treated as 00.
- ALUOut_M  in  32  forwarded value from MEM.
- Result_W  in  32  forwarded value from WB.
- ALUOut_E  out  32  ALU result, or HI/LO for MFHI/MFLO.
- WriteData_E  out  32  forwarded B operand, before the ALUSrc mux.
- WriteReg_E  out  5  Rd_E if RegDst=1, else Rt_E.
- Zero_E  out  1  1 when ALUOut_E == 0.
- Busy_E  out  1  mult/div running; the hazard unit stalls IF/ID and holds ID/EX.

## Operation
- SrcA = ForwardA mux. WriteData_E = ForwardB mux. SrcB = ALUSrc ? SignImm_E : WriteData_E.
- ALUControl encoding:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 011 XOR, 100 NOR.
  - 111 SLT (signed), 101 SLTU (unsigned). Both produce 32'd0 or 32'd1.
- Arithmetic is modulo 2^32. No overflow trap and no overflow flag.
- MFHI/MFLO override the ALU: ALUOut_E = HI or LO. Zero_E follows ALUOut_E.
- Mult/div FSM states:
  - IDLE. On a MULT/MULTU/DIV/DIVU op in MD_E: latch the forwarded SrcA/WriteData_E operands (absolute values for signed ops, with sign flags kept), clear the 6-bit counter, go to RUN.
  - RUN. Perform one shift-add (mult) or restoring shift-subtract (div) step per cycle. On the edge where counter == 31: apply sign fix-up, write HI/LO, return to IDLE.
- Mult: {HI,LO} = 64-bit product. MULT is signed; MULTU is unsigned.
- Div: LO = quotient, HI = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = dividend. No exception.
- A mult/div op presented in RUN is ignored. It must not restart the unit or corrupt operands; the hazard unit guarantees this does not occur.
- MFHI/MFLO in RUN returns the old HI/LO combinationally. The hazard unit is responsible for holding it via Busy_E.
- HI/LO change only on the completion edge or on reset.

## Timing
- ALU, forwarding, WriteReg_E and Zero_E are purely combinational. Latency is 0 cycles.
- Mult/div latency: op sampled in IDLE at the edge ending cycle N.
  - Busy_E = 1 in cycles N+1 through N+32 (exactly 32 cycles).
  - HI/LO are valid and Busy_E = 0 from cycle N+33.
  - A new op may be accepted at the edge ending N+33.
- Back-to-back: an op presented in the first IDLE cycle after completion is accepted.
- Busy_E is decoded from the registered state. It has no combinational path from inputs.
- Reset values: state IDLE, counter 0, HI = 0, LO = 0, Busy_E = 0.
- Reset asserted during RUN aborts the operation. The next cycle has Busy_E = 0 and HI/LO = 0.
- Reset and an op in the same cycle: reset wins and the op is dropped.

## Test plan
- Forwarding/ALU: RD1_E=5, ForwardA=10, ALUOut_M=7, SignImm_E=3, ALUSrc=1, ADD -> ALUOut_E=10. ForwardB=01 with Result_W=0x55 -> WriteData_E=0x55.
- Compare and zero:
  - SrcA=0xFFFFFFFF, SrcB=1: SLT -> 1; SLTU -> 0.
  - SUB 9-9 -> ALUOut_E=0, Zero_E=1.
  - RegDst=1, Rd_E=12 -> WriteReg_E=12.
- MULT -3 * 7 -> Busy_E high for exactly 32 cycles. Then MFLO -> 0xFFFFFFEB, MFHI -> 0xFFFFFFFF. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=1.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Reset at cycle 10 of a MULT -> Busy_E=0 the next cycle; MFHI/MFLO -> 0. A following MULTU 6*7 completes normally with LO=42.
- DIVU issued at cycle 5 of a running MULT 3*4 -> ignored; after completion LO=12, HI=0, and Busy_E falls after 32 total cycles.
